// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/and/or/slt plus iterative
// unsigned multiply (shift-add) and divide/remainder (restoring).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             Ovf_o,
    output logic             Div0_o
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               live_q;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               div0_q, div0_d;

    logic               accept;
    logic               fin;

    logic [WIDTH-1:0]   add_res;
    logic [WIDTH-1:0]   sub_res;
    logic               add_ovf;
    logic               sub_ovf;
    logic               slt_res;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   mul_lo;

    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_hi;
    logic [WIDTH-1:0]   div_lo;

    // live_q keeps ready_o low until the first edge after reset release
    assign ready_o = live_q && (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign accept  = valid_i && ready_o;
    assign data_o  = result_q;
    assign Zero_o  = zero_q;
    assign Ovf_o   = ovf_q;
    assign Div0_o  = div0_q;

    assign add_res = data1_i + data2_i;
    assign sub_res = data1_i - data2_i;
    assign add_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (add_res[WIDTH-1] != data1_i[WIDTH-1]);
    assign sub_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (sub_res[WIDTH-1] != data1_i[WIDTH-1]);
    assign slt_res = $signed(data1_i) < $signed(data2_i);

    // Multiply: {hi,lo} starts as {0,B}; add A into hi when lo[0] set, then shift right
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign div_hi    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo    = {lo_q[WIDTH-2:0], div_ok};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        div0_d   = div0_q;
        fin      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = ALUCtrl_i;
                    a_d    = data1_i;
                    b_d    = data2_i;
                    ovf_d  = 1'b0;
                    div0_d = 1'b0;
                    case (ALUCtrl_i)
                        OP_ADD: begin
                            fin      = 1'b1;
                            result_d = add_res;
                            ovf_d    = add_ovf;
                        end
                        OP_SUB: begin
                            fin      = 1'b1;
                            result_d = sub_res;
                            ovf_d    = sub_ovf;
                        end
                        OP_AND: begin
                            fin      = 1'b1;
                            result_d = data1_i & data2_i;
                        end
                        OP_OR: begin
                            fin      = 1'b1;
                            result_d = data1_i | data2_i;
                        end
                        OP_SLT: begin
                            fin      = 1'b1;
                            result_d = {{(WIDTH-1){1'b0}}, slt_res};
                        end
                        OP_MUL: begin
                            state_d = S_MUL;
                            hi_d    = '0;
                            lo_d    = data2_i;
                            cnt_d   = CNT_LOAD;
                        end
                        default: begin
                            // divu / remu; a zero divisor short-circuits the iteration
                            if (data2_i == '0) begin
                                fin      = 1'b1;
                                div0_d   = 1'b1;
                                result_d = (ALUCtrl_i == OP_DIVU) ? {WIDTH{1'b1}} : data1_i;
                            end else begin
                                state_d = S_DIV;
                                hi_d    = '0;
                                lo_d    = data1_i;
                                cnt_d   = CNT_LOAD;
                            end
                        end
                    endcase
                end
            end

            S_MUL: begin
                hi_d = mul_hi;
                lo_d = mul_lo;
                if (cnt_q == '0) begin
                    fin      = 1'b1;
                    result_d = mul_lo;
                    ovf_d    = |mul_hi;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DIV: begin
                hi_d = div_hi;
                lo_d = div_lo;
                if (cnt_q == '0) begin
                    fin      = 1'b1;
                    result_d = (op_q == OP_DIVU) ? div_lo : div_hi;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            state_d = S_DONE;
            zero_d  = (result_d == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            live_q   <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes add/sub/and/or/slt in one cycle. Executes unsigned multiply, divide and remainder iteratively.
- Produces defined zero, overflow and divide-by-zero flags for every op.
- Sits between the ID/EX operand registers and the EX/MEM stage. The pipeline stalls on ready_o low and consumes the result on valid_o.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
valid_i  in  1  operands and op present
ready_o  out  1  block can accept an op this cycle
data1_i  in  WIDTH  operand A
data2_i  in  WIDTH  operand B
ALUCtrl_i  in  3  op: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed), 011 mul (unsigned, low half), 100 divu, 101 remu
valid_o  out  1  result valid
ready_i  in  1  consumer takes result
data_o  out  WIDTH  result
Zero_o  out  1  data_o == 0
Ovf_o  out  1  overflow flag
Div0_o  out  1  divide-by-zero flag

Behaviour:
- States: IDLE, MUL, DIV, DONE. ready_o = (state==IDLE). Accept = valid_i && ready_o.
- Operands and op are registered on accept. Input changes while busy are ignored.
- Single-cycle ops (add, sub, and, or, slt):
  - IDLE -> DONE on accept.
  - valid_o is high on the cycle after the accept edge.
- MUL:
  - Shift-add over WIDTH iterations.
  - IDLE -> MUL -> DONE; valid_o rises exactly WIDTH+1 cycles after the accept edge.
  - data_o = low WIDTH bits of the unsigned product.
  - Ovf_o = 1 iff the high WIDTH bits are nonzero.
- DIVU/REMU:
  - Restoring division over WIDTH iterations, same latency as MUL.
  - data_o = quotient (divu) or remainder (remu).
- Divide by zero (data2_i==0 on accept for divu/remu):
  - No iteration; IDLE -> DONE, valid_o next cycle.
  - divu: data_o = all ones. remu: data_o = data1_i.
  - Div0_o = 1.
- Arithmetic and flags:
  - add/sub wrap modulo 2^WIDTH; Ovf_o = signed two's-complement overflow.
  - slt: data_o = 1 if signed A < signed B, else 0. slt is overflow-free; Ovf_o = 0.
  - and/or: Ovf_o = 0.
  - Div0_o = 0 for all ops except divide-by-zero.
  - Zero_o = (data_o == 0) for every op.
- DONE state:
  - data_o and all flags are held stable while valid_o=1 && ready_i=0.
  - DONE && ready_i -> IDLE. No accept on that same cycle; peak throughput is 1 op per 2 cycles.
- Iteration counter: loads WIDTH-1 on entry to MUL/DIV and decrements each cycle. The transition to DONE occurs on the cycle the count is 0.
- Reset (rst_i low, any time including mid-iteration):
  - state = IDLE, valid_o = 0, data_o = 0, Zero_o = 0, Ovf_o = 0, Div0_o = 0, counter and accumulators = 0.
  - ready_o = 0 while rst_i is low, and 1 from the first edge after release.
  - Any in-flight op is discarded and never appears at the output.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then add 0x7FFFFFFF + 0x00000001 -> valid_o one cycle later, data_o = 0x80000000, Ovf_o = 1, Zero_o = 0.
- sub 5 - 5, then slt 0xFFFFFFFF vs 0x00000001:
  - sub -> data_o = 0, Zero_o = 1.
  - slt -> data_o = 1, Ovf_o = 0.
- mul 0x00010000 * 0x00010000 -> valid_o exactly 33 cycles after accept, data_o = 0, Ovf_o = 1, Zero_o = 1. ready_o stays low throughout.
- divu 100 / 7 -> data_o = 14; remu 100 / 7 -> data_o = 2. Both at 33-cycle latency.
- divu 0x1234 / 0 -> data_o = 0xFFFFFFFF, Div0_o = 1, latency 1. remu 0x1234 / 0 -> data_o = 0x1234.
- Backpressure and reset:
  - Hold ready_i = 0 for 10 cycles after valid_o -> data_o and flags are stable.
  - Assert rst_i low at iteration 15 of a mul -> outputs immediately 0, no valid_o after release.
  - A following add 2 + 3 -> data_o = 5.
